// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 word port between the I-side and D-side L1s.
// Latency: zero added cycles; the port mux is combinational, so an L2 hit completes in the request cycle.
// Backpressure: l2_stall locks the grant to the selected side; the unselected requester sees stall = 1.
module l2_port_arbiter #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int INIT_PRIO_D = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_stall,
  output logic [CNT_W-1:0]  i_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  owner_e           owner_q, owner_d;
  logic             prio_q, prio_d;       // 1 = D-side wins the next contention
  logic [CNT_W-1:0] i_wait_cnt_q, i_wait_cnt_d;
  logic [CNT_W-1:0] d_wait_cnt_q, d_wait_cnt_d;

  logic req_i, req_d;
  logic sel_vld, sel_is_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // Pick the requester that drives the port this cycle; a locked owner whose request
  // has dropped selects nobody so nothing stray reaches the L2.
  always_comb begin
    sel_vld  = 1'b0;
    sel_is_d = 1'b0;
    case (owner_q)
      OWN_I: begin
        sel_vld  = req_i;
        sel_is_d = 1'b0;
      end
      OWN_D: begin
        sel_vld  = req_d;
        sel_is_d = 1'b1;
      end
      default: begin
        if (req_i && req_d) begin
          sel_vld  = 1'b1;
          sel_is_d = prio_q;
        end else if (req_d) begin
          sel_vld  = 1'b1;
          sel_is_d = 1'b1;
        end else if (req_i) begin
          sel_vld  = 1'b1;
          sel_is_d = 1'b0;
        end
      end
    endcase
  end

  // Next owner/priority: lock on stall, release and hand priority to the other side on completion.
  always_comb begin
    owner_d = OWN_NONE;
    prio_d  = prio_q;
    if (sel_vld) begin
      if (l2_stall) begin
        owner_d = sel_is_d ? OWN_D : OWN_I;
      end else begin
        prio_d = ~sel_is_d;
      end
    end
  end

  // Saturating wait counters advance on every stalled cycle seen by each side.
  always_comb begin
    i_wait_cnt_d = i_wait_cnt_q;
    d_wait_cnt_d = d_wait_cnt_q;
    if (i_stall && (i_wait_cnt_q != CNT_MAX)) begin
      i_wait_cnt_d = i_wait_cnt_q + CNT_W'(1);
    end
    if (d_stall && (d_wait_cnt_q != CNT_MAX)) begin
      d_wait_cnt_d = d_wait_cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset shared with the L2.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      owner_q      <= OWN_NONE;
      prio_q       <= (INIT_PRIO_D != 0);
      i_wait_cnt_q <= '0;
      d_wait_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      i_wait_cnt_q <= i_wait_cnt_d;
      d_wait_cnt_q <= d_wait_cnt_d;
    end
  end

  // Port mux plus per-side stall/rdata steering; unselected requesters are held off.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_stall  = 1'b0;
    i_rdata  = '0;
    d_stall  = 1'b0;
    d_rdata  = '0;
    if (sel_vld && !sel_is_d) begin
      l2_read = i_read;
      l2_addr = i_addr;
      i_stall = l2_stall;
      i_rdata = l2_rdata;
    end else if (req_i) begin
      i_stall = 1'b1;
    end
    if (sel_vld && sel_is_d) begin
      l2_read  = d_read;
      l2_write = d_write;
      l2_addr  = d_addr;
      l2_wdata = d_wdata;
      d_stall  = l2_stall;
      d_rdata  = l2_rdata;
    end else if (req_d) begin
      d_stall = 1'b1;
    end
  end

  assign i_wait_cnt = i_wait_cnt_q;
  assign d_wait_cnt = d_wait_cnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: one task per scenario with inline expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Counters use a narrow width so saturation is reachable in a short run.
module tb_l2_port_arbiter;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [DATA_W-1:0] l2_wdata;
  logic [DATA_W-1:0] l2_rdata;
  logic              l2_stall;
  logic [CNT_W-1:0]  i_wait_cnt;
  logic [CNT_W-1:0]  d_wait_cnt;

  int checks   = 0;
  int failures = 0;

  l2_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_PRIO_D(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_stall(l2_stall),
    .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_reset = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    l2_rdata = '0; l2_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    l2_rdata = 32'hFFFF_FFFF;
    l2_stall = 1'b1;
    #2;
    checks++;
    if ({l2_read, l2_write} !== 2'b00) begin
      failures++; $display("FAIL reset_l2_rw got=%b exp=00", {l2_read, l2_write});
    end
    checks++;
    if (l2_addr !== 30'h0 || l2_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_l2_addr_wdata got=%h/%h exp=0/0", l2_addr, l2_wdata);
    end
    checks++;
    if ({i_stall, d_stall} !== 2'b00) begin
      failures++; $display("FAIL reset_stalls got=%b exp=00", {i_stall, d_stall});
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", i_rdata, d_rdata);
    end
    checks++;
    if (i_wait_cnt !== 4'd0 || d_wait_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", i_wait_cnt, d_wait_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_i_hit();
    do_reset();
    i_read = 1'b1; i_addr = 30'h100; l2_rdata = 32'hDEAD_BEEF; l2_stall = 1'b0;
    #2;
    checks++;
    if (i_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ihit_rdata got=%h exp=deadbeef", i_rdata);
    end
    checks++;
    if (i_stall !== 1'b0) begin
      failures++; $display("FAIL ihit_stall got=%b exp=0", i_stall);
    end
    checks++;
    if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_addr !== 30'h100) begin
      failures++; $display("FAIL ihit_port got=r%b w%b a%h exp=r1 w0 a100", l2_read, l2_write, l2_addr);
    end
    tick();
    // Port is free and D is now preferred: contention goes to D.
    d_read = 1'b1; d_addr = 30'h2A;
    #2;
    checks++;
    if (l2_addr !== 30'h2A || d_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ihit_prio_flip got=a%h rd%h exp=a2a rd deadbeef", l2_addr, d_rdata);
    end
    checks++;
    if (i_stall !== 1'b1 || i_rdata !== 32'h0) begin
      failures++; $display("FAIL ihit_loser got=s%b rd%h exp=s1 rd0", i_stall, i_rdata);
    end
    tick();
    idle();
    #2;
    checks++;
    if (i_wait_cnt !== 4'd1 || d_wait_cnt !== 4'd0) begin
      failures++; $display("FAIL ihit_counters got=%0d/%0d exp=1/0", i_wait_cnt, d_wait_cnt);
    end
    tick();
  endtask

  task automatic test_d_write_stall();
    do_reset();
    d_write = 1'b1; d_addr = 30'h2A; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
      l2_stall = (k < 5);
      #2;
      checks++;
      if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 30'h2A || l2_wdata !== 32'h1234_5678) begin
        failures++;
        $display("FAIL dwr_port cyc=%0d got=r%b w%b a%h d%h exp=r0 w1 a2a d12345678", k, l2_read, l2_write, l2_addr, l2_wdata);
      end
      checks++;
      if (d_stall !== (k < 5)) begin
        failures++; $display("FAIL dwr_stall cyc=%0d got=%b exp=%b", k, d_stall, (k < 5));
      end
      tick();
    end
    idle();
    #2;
    checks++;
    if (d_wait_cnt !== 4'd5 || i_wait_cnt !== 4'd0) begin
      failures++; $display("FAIL dwr_counters got=%0d/%0d exp=0/5", i_wait_cnt, d_wait_cnt);
    end
    checks++;
    if (l2_write !== 1'b0 || l2_read !== 1'b0) begin
      failures++; $display("FAIL dwr_idle got=r%b w%b exp=r0 w0", l2_read, l2_write);
    end
    tick();
    // Owner released: a lone I request is served immediately.
    i_read = 1'b1; i_addr = 30'h55;
    #2;
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== 30'h55) begin
      failures++; $display("FAIL dwr_release got=r%b a%h exp=r1 a55", l2_read, l2_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_contention();
    do_reset();
    i_read = 1'b1; i_addr = 30'h1A0; d_read = 1'b1; d_addr = 30'h2B0; l2_rdata = 32'hCAFE_0000;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) i_read = 1'b0;
      l2_stall = ((k % 4) != 3);
      #2;
      if (k < 4) begin
        checks++;
        if (l2_addr !== 30'h1A0 || i_stall !== (k < 3) || d_stall !== 1'b1 || d_rdata !== 32'h0) begin
          failures++;
          $display("FAIL cont_i cyc=%0d got=a%h is%b ds%b drd%h exp=a1a0 is%b ds1 drd0", k, l2_addr, i_stall, d_stall, d_rdata, (k < 3));
        end
      end else begin
        checks++;
        if (l2_addr !== 30'h2B0 || d_stall !== (k < 7) || i_stall !== 1'b0) begin
          failures++;
          $display("FAIL cont_d cyc=%0d got=a%h is%b ds%b exp=a2b0 is0 ds%b", k, l2_addr, i_stall, d_stall, (k < 7));
        end
      end
      tick();
    end
    idle();
    #2;
    checks++;
    if (d_wait_cnt !== 4'd7 || i_wait_cnt !== 4'd3) begin
      failures++; $display("FAIL cont_counters got=%0d/%0d exp=3/7", i_wait_cnt, d_wait_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_i;
    int n_d;
    n_i = 0;
    n_d = 0;
    do_reset();
    i_read = 1'b1; i_addr = 30'h111; d_read = 1'b1; d_addr = 30'h222; l2_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (l2_addr === 30'h111) n_i++;
      if (l2_addr === 30'h222) n_d++;
      checks++;
      if (l2_addr !== (((k % 2) == 1) ? 30'h222 : 30'h111)) begin
        failures++; $display("FAIL b2b_grant cyc=%0d got=%h exp=%h", k, l2_addr, (((k % 2) == 1) ? 30'h222 : 30'h111));
      end
      tick();
    end
    checks++;
    if (n_i != 5 || n_d != 5) begin
      failures++; $display("FAIL b2b_share got=%0d/%0d exp=5/5", n_i, n_d);
    end
    idle();
    #2;
    checks++;
    if (i_wait_cnt !== 4'd5 || d_wait_cnt !== 4'd5) begin
      failures++; $display("FAIL b2b_counters got=%0d/%0d exp=5/5", i_wait_cnt, d_wait_cnt);
    end
    tick();
  endtask

  task automatic test_lock_midway();
    do_reset();
    // One I hit first so D holds priority; the lock must still keep I on the port.
    i_read = 1'b1; i_addr = 30'h300; l2_stall = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) begin
        d_write = 1'b1; d_addr = 30'h400; d_wdata = 32'hA5A5_A5A5;
      end
      l2_stall = (k < 4);
      #2;
      checks++;
      if (l2_addr !== 30'h300 || l2_write !== 1'b0 || i_stall !== (k < 4)) begin
        failures++; $display("FAIL lock_port cyc=%0d got=a%h w%b is%b exp=a300 w0 is%b", k, l2_addr, l2_write, i_stall, (k < 4));
      end
      if (k >= 1) begin
        checks++;
        if (d_stall !== 1'b1) begin
          failures++; $display("FAIL lock_dstall cyc=%0d got=%b exp=1", k, d_stall);
        end
      end
      tick();
    end
    i_read = 1'b0; l2_stall = 1'b0;
    #2;
    checks++;
    if (l2_addr !== 30'h400 || l2_write !== 1'b1 || l2_wdata !== 32'hA5A5_A5A5 || d_stall !== 1'b0) begin
      failures++; $display("FAIL lock_handover got=a%h w%b d%h ds%b exp=a400 w1 da5a5a5a5 ds0", l2_addr, l2_write, l2_wdata, d_stall);
    end
    tick();
    idle();
  endtask

  task automatic test_violation();
    do_reset();
    i_read = 1'b1; i_addr = 30'h77; l2_stall = 1'b1;
    tick();
    // Owner I drops its request mid-stall: nothing reaches the L2 this cycle.
    i_read = 1'b0; d_read = 1'b1; d_addr = 30'h88;
    #2;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || l2_addr !== 30'h0) begin
      failures++; $display("FAIL viol_port got=r%b w%b a%h exp=r0 w0 a0", l2_read, l2_write, l2_addr);
    end
    checks++;
    if (d_stall !== 1'b1 || i_stall !== 1'b0) begin
      failures++; $display("FAIL viol_stalls got=is%b ds%b exp=is0 ds1", i_stall, d_stall);
    end
    tick();
    l2_stall = 1'b0;
    #2;
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== 30'h88) begin
      failures++; $display("FAIL viol_recover got=r%b a%h exp=r1 a88", l2_read, l2_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_read = 1'b1; i_addr = 30'h98; l2_stall = 1'b0;
    tick();
    d_read = 1'b1; d_addr = 30'h99; l2_stall = 1'b1;
    #2;
    checks++;
    if (l2_addr !== 30'h99) begin
      failures++; $display("FAIL rmid_owner_d got=%h exp=99", l2_addr);
    end
    tick();
    tick();
    proc_reset = 1'b1;
    tick();
    idle();
    #2;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      failures++; $display("FAIL rmid_port got=r%b w%b exp=r0 w0", l2_read, l2_write);
    end
    checks++;
    if (i_wait_cnt !== 4'd0 || d_wait_cnt !== 4'd0) begin
      failures++; $display("FAIL rmid_counters got=%0d/%0d exp=0/0", i_wait_cnt, d_wait_cnt);
    end
    // Owner and priority are back to their reset values: contention goes to I.
    i_read = 1'b1; i_addr = 30'h98; d_read = 1'b1; d_addr = 30'h99;
    #1;
    checks++;
    if (l2_addr !== 30'h98 || d_stall !== 1'b1) begin
      failures++; $display("FAIL rmid_prio got=a%h ds%b exp=a98 ds1", l2_addr, d_stall);
    end
    tick();
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    i_read = 1'b1; i_addr = 30'h5; l2_stall = 1'b1;
    repeat (20) tick();
    #2;
    checks++;
    if (i_wait_cnt !== 4'hF || d_wait_cnt !== 4'd0) begin
      failures++; $display("FAIL sat_counters got=%0d/%0d exp=15/0", i_wait_cnt, d_wait_cnt);
    end
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_i_hit();
    test_d_write_stall();
    test_contention();
    test_back_to_back();
    test_lock_midway();
    test_violation();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
